rf_cmd_master: RTL and testbench

RF_CMD_MASTER -- requirements
Module: rf_cmd_master

---
 rtl/rf_cmd_master.sv | 200 ++++++++++++++++++++
 tb/tb_rf_cmd_master.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_cmd_master.sv
// Byte-command master: 0xAA <addr> <data> writes a register, 0xBB <addr> reads one and
// returns the byte on the transmitter. Define RF_WR_ACK_EN to also send 0xA5 after each write.
module rf_cmd_master #(
    parameter int WIDTH = 8,
    parameter int ADDR  = 4,
    parameter int TMO   = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] RX_P_DATA,
    input  logic             RX_D_VLD,
    output logic             WrEn,
    output logic             RdEn,
    output logic [ADDR-1:0]  Address,
    output logic [WIDTH-1:0] WrData,
    input  logic [WIDTH-1:0] RdData,
    input  logic             RdData_VLD,
    output logic [WIDTH-1:0] TX_P_DATA,
    output logic             TX_D_VLD,
    input  logic             TX_BUSY,
    output logic             ERR_CMD
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_ADDR = 3'd1,
        WR_DATA = 3'd2,
        RD_ADDR = 3'd3,
        RD_WAIT = 3'd4,
        TX_SEND = 3'd5
    } state_t;

    localparam int CW = (TMO > 1) ? $clog2(TMO) : 1;
    localparam logic [WIDTH-1:0] CMD_WR = WIDTH'(8'hAA);
    localparam logic [WIDTH-1:0] CMD_RD = WIDTH'(8'hBB);

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] buf_q, buf_d;
    logic             wr_en_q, wr_en_d;
    logic             rd_en_q, rd_en_d;
    logic             tx_vld_q, tx_vld_d;
    logic             err_q, err_d;
    logic [ADDR-1:0]  addr_q, addr_d;
    logic [WIDTH-1:0] wr_data_q, wr_data_d;
    logic [WIDTH-1:0] tx_data_q, tx_data_d;
    logic             timeout_s;

    // Last counted cycle of the read wait: count values 0..TMO-1 cover TMO cycles.
    assign timeout_s = (cnt_q == CW'(TMO - 1));

    // State register and read-wait counter.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state decode.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (RX_D_VLD && (RX_P_DATA == CMD_WR))      state_d = WR_ADDR;
                else if (RX_D_VLD && (RX_P_DATA == CMD_RD)) state_d = RD_ADDR;
                else                                        state_d = IDLE;
            end
            WR_ADDR: begin
                if (RX_D_VLD) state_d = WR_DATA;
                else          state_d = WR_ADDR;
            end
            WR_DATA: begin
                if (RX_D_VLD) begin
`ifdef RF_WR_ACK_EN
                    state_d = TX_SEND;
`else
                    state_d = IDLE;
`endif
                end else begin
                    state_d = WR_DATA;
                end
            end
            RD_ADDR: begin
                if (RX_D_VLD) state_d = RD_WAIT;
                else          state_d = RD_ADDR;
            end
            RD_WAIT: begin
                if (RdData_VLD)     state_d = TX_SEND;
                else if (timeout_s) state_d = IDLE;
                else                state_d = RD_WAIT;
            end
            TX_SEND: begin
                if (!TX_BUSY) state_d = IDLE;
                else          state_d = TX_SEND;
            end
            default: state_d = IDLE;
        endcase
    end

    // Strobe and datapath next values; strobes are single-cycle because they default low.
    always_comb begin
        wr_en_d   = 1'b0;
        rd_en_d   = 1'b0;
        tx_vld_d  = 1'b0;
        err_d     = 1'b0;
        addr_d    = addr_q;
        wr_data_d = wr_data_q;
        tx_data_d = tx_data_q;
        buf_d     = buf_q;
        cnt_d     = cnt_q;
        case (state_q)
            IDLE: begin
                if (RX_D_VLD && (RX_P_DATA != CMD_WR) && (RX_P_DATA != CMD_RD)) err_d = 1'b1;
                else                                                            err_d = 1'b0;
            end
            WR_ADDR: begin
                if (RX_D_VLD) addr_d = RX_P_DATA[ADDR-1:0];
                else          addr_d = addr_q;
            end
            WR_DATA: begin
                if (RX_D_VLD) begin
                    wr_data_d = RX_P_DATA;
                    wr_en_d   = 1'b1;
`ifdef RF_WR_ACK_EN
                    buf_d     = WIDTH'(8'hA5);
`else
                    buf_d     = buf_q;
`endif
                end else begin
                    wr_en_d   = 1'b0;
                end
            end
            RD_ADDR: begin
                if (RX_D_VLD) begin
                    addr_d  = RX_P_DATA[ADDR-1:0];
                    rd_en_d = 1'b1;
                    cnt_d   = '0;
                end else begin
                    rd_en_d = 1'b0;
                end
            end
            RD_WAIT: begin
                if (RdData_VLD) begin
                    buf_d = RdData;
                    cnt_d = '0;
                end else if (timeout_s) begin
                    err_d = 1'b1;
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            TX_SEND: begin
                if (!TX_BUSY) begin
                    tx_data_d = buf_q;
                    tx_vld_d  = 1'b1;
                end else begin
                    tx_vld_d  = 1'b0;
                end
            end
            default: err_d = 1'b0;
        endcase
    end

    // Registered outputs and holding registers.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            wr_en_q   <= 1'b0;
            rd_en_q   <= 1'b0;
            tx_vld_q  <= 1'b0;
            err_q     <= 1'b0;
            addr_q    <= '0;
            wr_data_q <= '0;
            tx_data_q <= '0;
            buf_q     <= '0;
        end else begin
            wr_en_q   <= wr_en_d;
            rd_en_q   <= rd_en_d;
            tx_vld_q  <= tx_vld_d;
            err_q     <= err_d;
            addr_q    <= addr_d;
            wr_data_q <= wr_data_d;
            tx_data_q <= tx_data_d;
            buf_q     <= buf_d;
        end
    end

    assign WrEn      = wr_en_q;
    assign RdEn      = rd_en_q;
    assign Address   = addr_q;
    assign WrData    = wr_data_q;
    assign TX_P_DATA = tx_data_q;
    assign TX_D_VLD  = tx_vld_q;
    assign ERR_CMD   = err_q;

endmodule

// File: tb/tb_rf_cmd_master.sv
// Self-checking bench for rf_cmd_master: directed vector table, corner sequences,
// and random commands checked against a transaction-level model.
`timescale 1ns/1ps
module tb_rf_cmd_master;
    localparam int TMO = 8;
`ifdef RF_WR_ACK_EN
    localparam int ACK = 1;
`else
    localparam int ACK = 0;
`endif

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic [7:0] RX_P_DATA = 8'h00;
    logic       RX_D_VLD = 1'b0;
    logic       WrEn, RdEn, TX_D_VLD, ERR_CMD;
    logic [3:0] Address;
    logic [7:0] WrData, TX_P_DATA;
    logic [7:0] RdData = 8'h00;
    logic       RdData_VLD = 1'b0;
    logic       TX_BUSY = 1'b0;

    rf_cmd_master #(.WIDTH(8), .ADDR(4), .TMO(TMO)) dut (
        .CLK(CLK), .RST(RST),
        .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
        .WrEn(WrEn), .RdEn(RdEn), .Address(Address), .WrData(WrData),
        .RdData(RdData), .RdData_VLD(RdData_VLD),
        .TX_P_DATA(TX_P_DATA), .TX_D_VLD(TX_D_VLD), .TX_BUSY(TX_BUSY),
        .ERR_CMD(ERR_CMD)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    // Observed events, recorded only by the monitor.
    logic [11:0] wr_q[$];
    logic [3:0]  rda_q[$];
    logic [7:0]  tx_q[$];
    int          err_cnt = 0;
    int          viol_cnt = 0;
    logic        wr_prev = 1'b0, rd_prev = 1'b0, tx_prev = 1'b0, er_prev = 1'b0;

    always @(negedge CLK) begin
        if (WrEn)     wr_q.push_back({Address, WrData});
        if (RdEn)     rda_q.push_back(Address);
        if (TX_D_VLD) tx_q.push_back(TX_P_DATA);
        if (ERR_CMD)  err_cnt++;
        if ((WrEn && RdEn) || (WrEn && wr_prev) || (RdEn && rd_prev) ||
            (TX_D_VLD && tx_prev) || (ERR_CMD && er_prev))
            viol_cnt++;
        wr_prev = WrEn;
        rd_prev = RdEn;
        tx_prev = TX_D_VLD;
        er_prev = ERR_CMD;
    end

    // Register-file read responder: VLD rd_delay cycles after RdEn, held two cycles,
    // second cycle carrying different data that must be ignored.
    int         rd_delay = -1;
    logic [7:0] rd_value = 8'h00;
    always begin
        @(negedge CLK);
        if (RdEn && rd_delay >= 1) begin
            repeat (rd_delay) @(posedge CLK);
            #1;
            RdData     = rd_value;
            RdData_VLD = 1'b1;
            @(posedge CLK);
            #1;
            RdData     = ~rd_value;
            @(posedge CLK);
            #1;
            RdData_VLD = 1'b0;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        RX_P_DATA = b;
        RX_D_VLD  = 1'b1;
        @(posedge CLK);
        #1;
        RX_D_VLD  = 1'b0;
    endtask

    task automatic run_cmd(input logic [7:0] c, input logic [7:0] a, input logic [7:0] d,
                           input int n, input int rdly, input int busy, input logic [7:0] rv);
        rd_delay = rdly;
        rd_value = rv;
        @(posedge CLK);
        #1;
        TX_BUSY = (busy > 0);
        send_byte(c);
        if (n > 1) send_byte(a);
        if (n > 2) send_byte(d);
        repeat (busy) @(posedge CLK);
        #1;
        TX_BUSY = 1'b0;
        repeat (TMO + 14) @(posedge CLK);
        #1;
    endtask

    typedef struct {
        logic [7:0] cmd, a, d;
        int         nbytes, rdly, busy;
        logic [7:0] rdval;
        int         exp_wr;
        logic [7:0] exp_addr, exp_wdata;
        int         exp_rd, exp_tx;
        logic [7:0] exp_txb;
        int         exp_err;
    } vec_t;

    initial begin
        vec_t       vecs[9];
        int         w0, r0, t0, e0, v0, n;
        logic [7:0] a, d, rv, c;
        int         kind, rdly, busy, m_err;
        logic [11:0] m_wr[$];
        logic [3:0]  m_rda[$];
        logic [7:0]  m_tx[$];

        //           cmd    a      d      n  rdly bsy rdval  wr addr   wdata  rd tx   txb    err
        vecs[0] = '{8'hAA, 8'h05, 8'h3C, 3, -1,  0, 8'h00, 1, 8'h05, 8'h3C, 0, ACK, 8'hA5, 0};
        vecs[1] = '{8'hAA, 8'hF7, 8'hC3, 3, -1,  3, 8'h00, 1, 8'h07, 8'hC3, 0, ACK, 8'hA5, 0};
        vecs[2] = '{8'hBB, 8'h02, 8'h00, 2,  1,  0, 8'h81, 0, 8'h02, 8'h00, 1, 1,   8'h81, 0};
        vecs[3] = '{8'h7E, 8'h00, 8'h00, 1, -1,  0, 8'h00, 0, 8'h00, 8'h00, 0, 0,   8'h00, 1};
        vecs[4] = '{8'hBB, 8'h0A, 8'h00, 2,  1, 20, 8'h5A, 0, 8'h0A, 8'h00, 1, 1,   8'h5A, 0};
        vecs[5] = '{8'hBB, 8'h03, 8'h00, 2, -1,  0, 8'h00, 0, 8'h03, 8'h00, 1, 0,   8'h00, 1};
        vecs[6] = '{8'hBB, 8'h0C, 8'h00, 2,  7,  0, 8'hC6, 0, 8'h0C, 8'h00, 1, 1,   8'hC6, 0};
        vecs[7] = '{8'hBB, 8'h03, 8'h00, 2,  8,  0, 8'h99, 0, 8'h03, 8'h00, 1, 0,   8'h00, 1};
        vecs[8] = '{8'h00, 8'h00, 8'h00, 1, -1,  0, 8'h00, 0, 8'h00, 8'h00, 0, 0,   8'h00, 1};

        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("rst_strobes", {WrEn, RdEn, TX_D_VLD, ERR_CMD}, 4'b0000);
        check("rst_address", Address, 4'h0);
        check("rst_wrdata", WrData, 8'h00);
        check("rst_txdata", TX_P_DATA, 8'h00);
        @(posedge CLK);
        #1;
        RST = 1'b1;

        for (int i = 0; i < 9; i++) begin
            w0 = wr_q.size(); r0 = rda_q.size(); t0 = tx_q.size(); e0 = err_cnt; v0 = viol_cnt;
            run_cmd(vecs[i].cmd, vecs[i].a, vecs[i].d, vecs[i].nbytes, vecs[i].rdly,
                    vecs[i].busy, vecs[i].rdval);
            check($sformatf("vec%0d wr_count", i), wr_q.size() - w0, vecs[i].exp_wr);
            check($sformatf("vec%0d rd_count", i), rda_q.size() - r0, vecs[i].exp_rd);
            check($sformatf("vec%0d tx_count", i), tx_q.size() - t0, vecs[i].exp_tx);
            check($sformatf("vec%0d err_count", i), err_cnt - e0, vecs[i].exp_err);
            check($sformatf("vec%0d strobe_rules", i), viol_cnt - v0, 0);
            if (vecs[i].exp_wr > 0 && wr_q.size() > w0)
                check($sformatf("vec%0d wr_addr_data", i), wr_q[w0],
                      {vecs[i].exp_addr[3:0], vecs[i].exp_wdata});
            if (vecs[i].exp_rd > 0 && rda_q.size() > r0)
                check($sformatf("vec%0d rd_addr", i), rda_q[r0], vecs[i].exp_addr[3:0]);
            if (vecs[i].exp_tx > 0 && tx_q.size() > t0)
                check($sformatf("vec%0d tx_byte", i), tx_q[t0], vecs[i].exp_txb);
        end

        // Holding registers keep the last access values.
        check("hold_address", Address, 4'h3);
        check("hold_wrdata", WrData, 8'hC3);
        check("hold_txdata", TX_P_DATA, 8'hC6);

        // Asynchronous reset clears outputs without a clock edge.
        @(posedge CLK);
        #2;
        RST = 1'b0;
        #1;
        check("async_rst_address", Address, 4'h0);
        check("async_rst_wrdata", WrData, 8'h00);
        check("async_rst_txdata", TX_P_DATA, 8'h00);
        @(posedge CLK);
        #1;
        RST = 1'b1;

        // Read-wait timeout: ERR_CMD exactly TMO cycles after the RdEn cycle.
        rd_delay = -1;
        @(posedge CLK);
        #1;
        send_byte(8'hBB);
        send_byte(8'h01);
        @(negedge CLK);
        check("rden_after_addr", RdEn, 1'b1);
        n = 0;
        while (!ERR_CMD && n < 20) begin
            @(negedge CLK);
            n++;
        end
        check("timeout_cycles", n, TMO);

        // Busy transmitter: no send while busy, send on the cycle after it falls.
        t0 = tx_q.size();
        rd_delay = 1;
        rd_value = 8'h3E;
        @(posedge CLK);
        #1;
        TX_BUSY = 1'b1;
        send_byte(8'hBB);
        send_byte(8'h04);
        repeat (20) @(posedge CLK);
        #1;
        check("busy_no_tx", tx_q.size() - t0, 0);
        TX_BUSY = 1'b0;
        @(negedge CLK);
        check("busy_fall_cycle", TX_D_VLD, 1'b0);
        @(negedge CLK);
        check("busy_next_cycle", TX_D_VLD, 1'b1);
        check("busy_tx_byte", TX_P_DATA, 8'h3E);
        repeat (6) @(posedge CLK);
        check("busy_tx_once", tx_q.size() - t0, 1);

        // Bytes arriving during RD_WAIT are dropped silently.
        w0 = wr_q.size(); t0 = tx_q.size(); e0 = err_cnt;
        rd_delay = 4;
        rd_value = 8'h6D;
        @(posedge CLK);
        #1;
        send_byte(8'hBB);
        send_byte(8'h02);
        send_byte(8'hAA);
        send_byte(8'h7E);
        repeat (TMO + 10) @(posedge CLK);
        #1;
        check("drop_no_err", err_cnt - e0, 0);
        check("drop_no_wr", wr_q.size() - w0, 0);
        check("drop_tx_count", tx_q.size() - t0, 1);
        if (tx_q.size() > t0) check("drop_tx_byte", tx_q[t0], 8'h6D);

        // Reset during WR_DATA aborts the write.
        w0 = wr_q.size(); e0 = err_cnt;
        @(posedge CLK);
        #1;
        send_byte(8'hAA);
        send_byte(8'h09);
        #2;
        RST = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b1;
        send_byte(8'h3C);
        repeat (5) @(posedge CLK);
        #1;
        check("rst_abort_no_wr", wr_q.size() - w0, 0);
        check("rst_abort_byte_err", err_cnt - e0, 1);

        // Random commands against a transaction-level model.
        w0 = wr_q.size(); r0 = rda_q.size(); t0 = tx_q.size(); e0 = err_cnt; v0 = viol_cnt;
        m_err = 0;
        for (int i = 0; i < 40; i++) begin
            kind = $urandom_range(0, 2);
            a    = 8'($urandom);
            d    = 8'($urandom);
            rv   = 8'($urandom);
            rdly = $urandom_range(1, 11);
            busy = $urandom_range(0, 6);
            if (kind == 0) begin
                run_cmd(8'hAA, a, d, 3, rdly, busy, rv);
                m_wr.push_back({a[3:0], d});
                if (ACK == 1) m_tx.push_back(8'hA5);
            end else if (kind == 1) begin
                run_cmd(8'hBB, a, d, 2, rdly, busy, rv);
                m_rda.push_back(a[3:0]);
                if (rdly < TMO) m_tx.push_back(rv);
                else            m_err++;
            end else begin
                c = 8'($urandom);
                if (c == 8'hAA || c == 8'hBB) c = 8'h55;
                run_cmd(c, a, d, 1, rdly, busy, rv);
                m_err++;
            end
        end
        check("rnd_wr_count", wr_q.size() - w0, m_wr.size());
        check("rnd_rd_count", rda_q.size() - r0, m_rda.size());
        check("rnd_tx_count", tx_q.size() - t0, m_tx.size());
        check("rnd_err_count", err_cnt - e0, m_err);
        check("rnd_strobe_rules", viol_cnt - v0, 0);
        for (int i = 0; i < m_wr.size() && (w0 + i) < wr_q.size(); i++)
            check($sformatf("rnd_wr[%0d]", i), wr_q[w0 + i], m_wr[i]);
        for (int i = 0; i < m_rda.size() && (r0 + i) < rda_q.size(); i++)
            check($sformatf("rnd_rd_addr[%0d]", i), rda_q[r0 + i], m_rda[i]);
        for (int i = 0; i < m_tx.size() && (t0 + i) < tx_q.size(); i++)
            check($sformatf("rnd_tx[%0d]", i), tx_q[t0 + i], m_tx[i]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
